vga_layer_mixer: RTL and testbench
==================================

# vga_layer_mixer

Parametrised, pipelined successor to the fixed-priority screen compositor. Merges N_LAYERS sprite/pattern layers (draw flag + colour each) by strict priority over a constant background. Applies frame-synchronous full-screen effects (invert flash, brightness fade in/out) and delays the VGA syncs to match. Sits between the per-object pattern generators and the VGA output pins.

## Interface
Parameters:
- N_LAYERS, 6, number of layers; bit 0 = highest priority
- COLOR_W, 12, pixel width; 3 equal channels, 4 bits each at default
- BG_COLOR, 12'h0CF, colour when no enabled layer draws
- FLASH_FRAMES, 8, frames an invert flash lasts (≥1)
- FADE_STEP_FRAMES, 4, frames per brightness step (≥1)

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  synchronous, active-high reset
- iLayerDraw  in  N_LAYERS  per-layer draw flag
- iLayerColor  in  N_LAYERS*COLOR_W  layer k colour at [k*COLOR_W +: COLOR_W]
- iLayerMask  in  N_LAYERS  layer enable, shadowed at frame start
- iActive, iHSync, iVSync  in  1 each  timing from the sync generator
- iFrameStart  in  1  one-cycle pulse, first blanking cycle of each frame
- iFlashTrig  in  1  one-cycle request for an invert flash
- iFadeTrig  in  1  one-cycle request for a fade
- iFadeDir  in  1  sampled with iFadeTrig: 0 = fade out, 1 = fade in
- oRed, oGreen, oBlue  out  COLOR_W/3 each  pixel
- oHSync, oVSync, oActive  out  1 each  syncs delayed to match pixel latency
- oBusy  out  1  effect pending or running

## Operation
- Mask shadow: reset to all ones; loads iLayerMask only on iFrameStart, so no mid-frame tearing.
- Stage 1: lowest index k with iLayerDraw[k] & mask[k] selects iLayerColor[k]; none selected gives BG_COLOR. Registered with iActive/iHSync/iVSync.
- Stage 2: effect applied per channel. Inversion (FLASH) is c' = ~c. Scaling is c'' = (c' * level) >> 4, with level 5 bits in 0..16, 9-bit product, result truncated to channel width. oActive=0 forces 0 on all channels.
- Effect FSM states are IDLE, FLASH, FADE_OUT, FADE_IN.
  - A trigger in IDLE sets a pending request (oBusy=1). The state is entered at the next iFrameStart.
  - Triggers while pending or running are ignored.
  - Flash and fade trigger in the same cycle: fade wins, flash dropped.
  - FLASH: frame counter counts iFrameStart pulses; after FLASH_FRAMES pulses, returns to IDLE.
  - FADE_OUT: every FADE_STEP_FRAMES frame starts, level decrements; reaching 0 returns to IDLE.
  - FADE_IN: level increments the same way; reaching 16 returns to IDLE.
  - Level persists in IDLE, so the screen stays black after a fade-out.
  - A fade-out at level 0, or a fade-in at 16, enters its state and exits at the first step boundary with level unchanged.
- Reset values:
  - level=16, state IDLE, no pending request, counters 0.
  - All outputs 0; oHSync/oVSync 0 until the pipeline refills.
- Reset mid-effect aborts immediately to full brightness.

## Timing
- Latency is 2 cycles from inputs to oRed/oGreen/oBlue/oHSync/oVSync/oActive, constant for all modes.
- Effect state and level change only in the cycle after iFrameStart. They are constant across the visible region of a frame.
- oBusy rises the cycle after the accepted trigger and falls the cycle after the state returns to IDLE.
- Mask change is visible on pixels sampled after the iFrameStart cycle.

## Structure
- Shared package vga_pkg holds the effect state enum, LEVEL_MAX=16, LEVEL_W=5, and channel-width helper constants.
- Sub-module vga_fx_ctrl holds the FSM, pending flags, frame/step counters and the level register; it outputs invert and level.
- The top holds the mask shadow, the priority mux, the two pipeline stages and the sync delay.

## Test plan
- Layers 0 and 2 draw (12'hF00, 12'h0F0), mask all ones: output 12'hF00 two cycles later. Clear mask[0] and pulse iFrameStart: 12'h0F0 from the next frame. No draw: 12'h0CF.
- iActive=0 with layer drawing: output 0. The HSync pulse on the output is delayed exactly 2 cycles.
- iFlashTrig mid-frame: no change until iFrameStart. Then 12'h0CF displays as 12'hF30 for exactly 8 frames, and oBusy falls after the 8th pulse.
- Fade out, FADE_STEP_FRAMES=4: 12'hFFF steps to 15*15>>4 = 14 (12'hEEE) after 4 frames, and reaches 0 after 64 frames. Fade in then restores 12'hFFF after 64 frames.
- iFlashTrig and iFadeTrig (dir 0) in the same cycle: only the fade runs. A second trigger during the fade is ignored.
- iRst asserted during FADE_OUT at level 7: next cycle state IDLE, level 16, outputs 0. After 2 cycles the full-brightness pixel returns.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA layer mixer.
//   fxState_t   - effect controller states
//   LEVEL_MAX   - full-brightness level (scale factor 16/16)
//   LEVEL_W     - width of the brightness level
//   LEVEL_SHIFT - right shift that turns channel*level back into a channel
//   N_CHANNELS  - colour channels per pixel (R, G, B)
package vga_pkg;
   typedef enum logic [1:0] {IDLE, FLASH, FADE_OUT, FADE_IN} fxState_t;
   localparam int LEVEL_MAX   = 16;
   localparam int LEVEL_W     = 5;
   localparam int LEVEL_SHIFT = 4;
   localparam int N_CHANNELS  = 3;
   function automatic int chanWidth(input int colorW);
      return colorW / N_CHANNELS;
   endfunction
endpackage

// File: rtl/vga_fx_ctrl.sv
// vga_fx_ctrl: frame-synchronous effect controller (invert flash, brightness fade).
//   iClk, iRst         - pixel clock, synchronous active-high reset
//   iFrameStart        - one-cycle pulse at the start of each frame
//   iFlashTrig         - request an invert flash
//   iFadeTrig/iFadeDir - request a fade, direction 0 = out, 1 = in
//   oInvert            - invert all channels this frame
//   oLevel             - brightness level 0..16
//   oBusy              - request pending or effect running
module vga_fx_ctrl
   import vga_pkg::*;
#(
   parameter int FLASH_FRAMES     = 8,
   parameter int FADE_STEP_FRAMES = 4
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic               iFrameStart,
   input  logic               iFlashTrig,
   input  logic               iFadeTrig,
   input  logic               iFadeDir,
   output logic               oInvert,
   output logic [LEVEL_W-1:0] oLevel,
   output logic               oBusy
);
   localparam int CNT_MAX = FLASH_FRAMES > FADE_STEP_FRAMES ? FLASH_FRAMES : FADE_STEP_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   fxState_t state, stateNext;
   logic [LEVEL_W-1:0] level, levelNext, levelDn, levelUp;
   logic [CNT_W-1:0] frameCnt, frameCntNext;
   logic pendFlash, pendFadeOut, pendFadeIn;
   logic pendFlashNext, pendFadeOutNext, pendFadeInNext;
   logic pending;
   assign pending = pendFlash | pendFadeOut | pendFadeIn;
   // Saturating steps: a fade already at its end level exits without moving.
   assign levelDn = level == '0 ? level : level - LEVEL_W'(1);
   assign levelUp = level == LEVEL_W'(LEVEL_MAX) ? level : level + LEVEL_W'(1);
   always_comb begin
      stateNext       = state;
      levelNext       = level;
      frameCntNext    = frameCnt;
      pendFlashNext   = pendFlash;
      pendFadeOutNext = pendFadeOut;
      pendFadeInNext  = pendFadeIn;
      // Only an idle controller accepts a request; fade beats a simultaneous flash.
      if (state == IDLE && !pending) begin
         pendFadeOutNext = iFadeTrig & ~iFadeDir;
         pendFadeInNext  = iFadeTrig & iFadeDir;
         pendFlashNext   = iFlashTrig & ~iFadeTrig;
      end
      if (iFrameStart) begin
         case (state)
            IDLE: if (pending) begin
               stateNext       = pendFlash ? FLASH : pendFadeOut ? FADE_OUT : FADE_IN;
               frameCntNext    = '0;
               pendFlashNext   = 1'b0;
               pendFadeOutNext = 1'b0;
               pendFadeInNext  = 1'b0;
            end
            FLASH: if (frameCnt == CNT_W'(FLASH_FRAMES - 1)) begin
               stateNext    = IDLE;
               frameCntNext = '0;
            end else frameCntNext = frameCnt + CNT_W'(1);
            FADE_OUT, FADE_IN: if (frameCnt == CNT_W'(FADE_STEP_FRAMES - 1)) begin
               frameCntNext = '0;
               levelNext    = state == FADE_OUT ? levelDn : levelUp;
               if (levelNext == (state == FADE_OUT ? LEVEL_W'(0) : LEVEL_W'(LEVEL_MAX)))
                  stateNext = IDLE;
            end else frameCntNext = frameCnt + CNT_W'(1);
            default: stateNext = IDLE;
         endcase
      end
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state       <= IDLE;
         level       <= LEVEL_W'(LEVEL_MAX);
         frameCnt    <= '0;
         pendFlash   <= 1'b0;
         pendFadeOut <= 1'b0;
         pendFadeIn  <= 1'b0;
      end else begin
         state       <= stateNext;
         level       <= levelNext;
         frameCnt    <= frameCntNext;
         pendFlash   <= pendFlashNext;
         pendFadeOut <= pendFadeOutNext;
         pendFadeIn  <= pendFadeInNext;
      end
   end
   assign oInvert = state == FLASH;
   assign oLevel  = level;
   assign oBusy   = pending | (state != IDLE);
endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: priority compositor of N_LAYERS layers over a background,
// followed by frame-synchronous invert/brightness effects; 2-cycle latency.
//   iClk, iRst              - pixel clock, synchronous active-high reset
//   iLayerDraw/iLayerColor  - per-layer draw flag and colour (layer 0 wins)
//   iLayerMask              - layer enables, shadowed on iFrameStart
//   iActive/iHSync/iVSync   - timing from the sync generator
//   iFrameStart             - one-cycle pulse at the start of each frame
//   iFlashTrig/iFadeTrig/iFadeDir - effect requests
//   oRed/oGreen/oBlue       - output pixel
//   oHSync/oVSync/oActive   - timing delayed to match the pixel
//   oBusy                   - effect pending or running
module vga_layer_mixer
   import vga_pkg::*;
#(
   parameter int N_LAYERS                 = 6,
   parameter int COLOR_W                  = 12,
   parameter logic [COLOR_W-1:0] BG_COLOR = 12'h0CF,
   parameter int FLASH_FRAMES             = 8,
   parameter int FADE_STEP_FRAMES         = 4
) (
   input  logic                             iClk,
   input  logic                             iRst,
   input  logic [N_LAYERS-1:0]              iLayerDraw,
   input  logic [N_LAYERS*COLOR_W-1:0]      iLayerColor,
   input  logic [N_LAYERS-1:0]              iLayerMask,
   input  logic                             iActive,
   input  logic                             iHSync,
   input  logic                             iVSync,
   input  logic                             iFrameStart,
   input  logic                             iFlashTrig,
   input  logic                             iFadeTrig,
   input  logic                             iFadeDir,
   output logic [COLOR_W/N_CHANNELS-1:0]    oRed,
   output logic [COLOR_W/N_CHANNELS-1:0]    oGreen,
   output logic [COLOR_W/N_CHANNELS-1:0]    oBlue,
   output logic                             oHSync,
   output logic                             oVSync,
   output logic                             oActive,
   output logic                             oBusy
);
   localparam int CH_W = chanWidth(COLOR_W);
   logic [N_LAYERS-1:0] mask;
   logic [COLOR_W-1:0] selColor, s1Color, scaled;
   logic s1Active, s1HSync, s1VSync;
   logic fxInvert;
   logic [LEVEL_W-1:0] fxLevel;
   vga_fx_ctrl #(
      .FLASH_FRAMES    (FLASH_FRAMES),
      .FADE_STEP_FRAMES(FADE_STEP_FRAMES)
   ) uFx (
      .iClk       (iClk),
      .iRst       (iRst),
      .iFrameStart(iFrameStart),
      .iFlashTrig (iFlashTrig),
      .iFadeTrig  (iFadeTrig),
      .iFadeDir   (iFadeDir),
      .oInvert    (fxInvert),
      .oLevel     (fxLevel),
      .oBusy      (oBusy)
   );
   // Scanning from the top down lets the lowest drawing index overwrite the rest.
   always_comb begin
      selColor = BG_COLOR;
      for (int k = N_LAYERS - 1; k >= 0; k--)
         if (iLayerDraw[k] & mask[k]) selColor = iLayerColor[k*COLOR_W +: COLOR_W];
   end
   for (genvar c = 0; c < N_CHANNELS; c++) begin : gCh
      logic [CH_W-1:0] inv;
      logic [CH_W+LEVEL_W-1:0] prod;
      assign inv  = fxInvert ? ~s1Color[c*CH_W +: CH_W] : s1Color[c*CH_W +: CH_W];
      assign prod = {{LEVEL_W{1'b0}}, inv} * {{CH_W{1'b0}}, fxLevel};
      assign scaled[c*CH_W +: CH_W] = prod[LEVEL_SHIFT +: CH_W];
   end
   if (COLOR_W > N_CHANNELS * CH_W) begin : gPad
      assign scaled[COLOR_W-1:N_CHANNELS*CH_W] = '0;
   end
   always_ff @(posedge iClk) begin
      if (iRst) begin
         mask     <= '1;
         s1Color  <= '0;
         s1Active <= 1'b0;
         s1HSync  <= 1'b0;
         s1VSync  <= 1'b0;
         oRed     <= '0;
         oGreen   <= '0;
         oBlue    <= '0;
         oActive  <= 1'b0;
         oHSync   <= 1'b0;
         oVSync   <= 1'b0;
      end else begin
         if (iFrameStart) mask <= iLayerMask;
         s1Color  <= selColor;
         s1Active <= iActive;
         s1HSync  <= iHSync;
         s1VSync  <= iVSync;
         oRed     <= s1Active ? scaled[2*CH_W +: CH_W] : '0;
         oGreen   <= s1Active ? scaled[CH_W +: CH_W] : '0;
         oBlue    <= s1Active ? scaled[0 +: CH_W] : '0;
         oActive  <= s1Active;
         oHSync   <= s1HSync;
         oVSync   <= s1VSync;
      end
   end
endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb_vga_layer_mixer: directed-vector bench for vga_layer_mixer at default parameters.
module tb_vga_layer_mixer;
   logic iClk = 1'b0, iRst = 1'b1;
   logic [5:0] iLayerDraw = '0, iLayerMask = '1;
   logic [71:0] iLayerColor;
   logic iActive = 1'b1, iHSync = 1'b0, iVSync = 1'b0, iFrameStart = 1'b0;
   logic iFlashTrig = 1'b0, iFadeTrig = 1'b0, iFadeDir = 1'b0;
   logic [3:0] oRed, oGreen, oBlue;
   logic oHSync, oVSync, oActive, oBusy;
   logic [11:0] pix;
   int vectors = 0, miscompares = 0;
   assign pix = {oRed, oGreen, oBlue};
   always #5 iClk = ~iClk;
   vga_layer_mixer dut (
      .iClk(iClk), .iRst(iRst), .iLayerDraw(iLayerDraw), .iLayerColor(iLayerColor),
      .iLayerMask(iLayerMask), .iActive(iActive), .iHSync(iHSync), .iVSync(iVSync),
      .iFrameStart(iFrameStart), .iFlashTrig(iFlashTrig), .iFadeTrig(iFadeTrig),
      .iFadeDir(iFadeDir), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
      .oHSync(oHSync), .oVSync(oVSync), .oActive(oActive), .oBusy(oBusy)
   );
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask
   // One frame: start pulse, then two cycles so the pipeline shows the new frame.
   task automatic frame();
      iFrameStart = 1'b1;
      tick();
      iFrameStart = 1'b0;
      tick(2);
   endtask
   task automatic test_reset();
      iLayerDraw = 6'b000001;
      iHSync = 1'b1;
      iVSync = 1'b1;
      tick(3);
      vectors++;
      if (pix !== 12'h000 || oHSync !== 1'b0 || oVSync !== 1'b0 || oActive !== 1'b0 || oBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: pix=%h hs=%b vs=%b act=%b busy=%b, want 000 0 0 0 0", pix, oHSync, oVSync, oActive, oBusy);
      end
      iHSync = 1'b0;
      iVSync = 1'b0;
      iRst = 1'b0;
      tick(2);
   endtask
   task automatic test_priority();
      logic [5:0] draws [5] = '{6'b000101, 6'b001010, 6'b111000, 6'b100000, 6'b000000};
      logic [11:0] exps [5] = '{12'hF00, 12'h00F, 12'hABC, 12'hFFF, 12'h0CF};
      for (int i = 0; i < 5; i++) begin
         iLayerDraw = draws[i];
         tick(2);
         vectors++;
         if (pix !== exps[i]) begin
            miscompares++;
            $display("FAIL priority[%0d]: pix=%h want %h", i, pix, exps[i]);
         end
      end
      iLayerDraw = 6'b000101;
      iLayerMask = 6'b111110;
      tick(2);
      vectors++;
      if (pix !== 12'hF00) begin
         miscompares++;
         $display("FAIL mask_before_frame: pix=%h want f00", pix);
      end
      frame();
      vectors++;
      if (pix !== 12'h0F0) begin
         miscompares++;
         $display("FAIL mask_after_frame: pix=%h want 0f0", pix);
      end
      iLayerMask = 6'b111111;
      frame();
      vectors++;
      if (pix !== 12'hF00) begin
         miscompares++;
         $display("FAIL mask_restore: pix=%h want f00", pix);
      end
   endtask
   task automatic test_active_sync();
      iActive = 1'b0;
      tick(2);
      vectors++;
      if (pix !== 12'h000 || oActive !== 1'b0) begin
         miscompares++;
         $display("FAIL blanking: pix=%h act=%b want 000 0", pix, oActive);
      end
      iActive = 1'b1;
      iHSync = 1'b1;
      tick();
      iHSync = 1'b0;
      vectors++;
      if (oHSync !== 1'b0) begin
         miscompares++;
         $display("FAIL hsync_d1: got %b want 0", oHSync);
      end
      tick();
      vectors++;
      if (oHSync !== 1'b1 || oActive !== 1'b1) begin
         miscompares++;
         $display("FAIL hsync_d2: hs=%b act=%b want 1 1", oHSync, oActive);
      end
      tick();
      vectors++;
      if (oHSync !== 1'b0) begin
         miscompares++;
         $display("FAIL hsync_d3: got %b want 0", oHSync);
      end
   endtask
   task automatic test_flash();
      iLayerDraw = 6'b000000;
      iFlashTrig = 1'b1;
      tick();
      iFlashTrig = 1'b0;
      tick(2);
      vectors++;
      if (pix !== 12'h0CF || oBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL flash_pending: pix=%h busy=%b want 0cf 1", pix, oBusy);
      end
      frame();
      for (int f = 1; f <= 8; f++) begin
         vectors++;
         if (pix !== 12'hF30 || oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL flash_frame%0d: pix=%h busy=%b want f30 1", f, pix, oBusy);
         end
         frame();
      end
      vectors++;
      if (pix !== 12'h0CF || oBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL flash_end: pix=%h busy=%b want 0cf 0", pix, oBusy);
      end
   endtask
   task automatic test_fade();
      iLayerDraw = 6'b100000;
      iFadeTrig = 1'b1;
      iFadeDir = 1'b0;
      tick();
      iFadeTrig = 1'b0;
      frame();
      for (int p = 1; p <= 64; p++) begin
         frame();
         if (p == 3 || p == 4 || p == 8 || p == 63 || p == 64) begin
            vectors++;
            if (pix !== (p == 3 ? 12'hFFF : p == 4 ? 12'hEEE : p == 8 ? 12'hDDD : 12'h000)
                || oBusy !== (p != 64)) begin
               miscompares++;
               $display("FAIL fade_out_p%0d: pix=%h busy=%b", p, pix, oBusy);
            end
         end
      end
      frame();
      vectors++;
      if (pix !== 12'h000) begin
         miscompares++;
         $display("FAIL black_persists: pix=%h want 000", pix);
      end
      iFadeTrig = 1'b1;
      iFadeDir = 1'b1;
      tick();
      iFadeTrig = 1'b0;
      frame();
      for (int p = 1; p <= 64; p++) begin
         frame();
         if (p == 4 || p == 8 || p == 63 || p == 64) begin
            vectors++;
            if (pix !== (p == 4 ? 12'h000 : p == 8 ? 12'h111 : p == 63 ? 12'hEEE : 12'hFFF)
                || oBusy !== (p != 64)) begin
               miscompares++;
               $display("FAIL fade_in_p%0d: pix=%h busy=%b", p, pix, oBusy);
            end
         end
      end
      iFadeTrig = 1'b1;
      tick();
      iFadeTrig = 1'b0;
      frame();
      for (int p = 1; p <= 4; p++) begin
         frame();
         vectors++;
         if (pix !== 12'hFFF || oBusy !== (p != 4)) begin
            miscompares++;
            $display("FAIL fade_in_at_max_p%0d: pix=%h busy=%b", p, pix, oBusy);
         end
      end
   endtask
   task automatic test_back_to_back();
      iFlashTrig = 1'b1;
      iFadeTrig = 1'b1;
      iFadeDir = 1'b0;
      tick();
      iFlashTrig = 1'b0;
      iFadeTrig = 1'b0;
      frame();
      vectors++;
      if (pix !== 12'hFFF || oBusy !== 1'b1) begin
         miscompares++;
         $display("FAIL simultaneous: pix=%h busy=%b want fff 1", pix, oBusy);
      end
      iFlashTrig = 1'b1;
      tick();
      iFlashTrig = 1'b0;
      for (int p = 1; p <= 36; p++) begin
         frame();
         if (p == 1 || p == 4 || p == 36) begin
            vectors++;
            if (pix !== (p == 1 ? 12'hFFF : p == 4 ? 12'hEEE : 12'h666)) begin
               miscompares++;
               $display("FAIL ignored_trig_p%0d: pix=%h", p, pix);
            end
         end
      end
      iRst = 1'b1;
      tick();
      vectors++;
      if (pix !== 12'h000 || oBusy !== 1'b0 || oActive !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_fade: pix=%h busy=%b act=%b want 000 0 0", pix, oBusy, oActive);
      end
      iRst = 1'b0;
      tick(2);
      vectors++;
      if (pix !== 12'hFFF) begin
         miscompares++;
         $display("FAIL after_reset: pix=%h want fff", pix);
      end
      frame();
      vectors++;
      if (pix !== 12'hFFF || oBusy !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset_frame: pix=%h busy=%b want fff 0", pix, oBusy);
      end
   endtask
   initial begin
      iLayerColor = {12'hFFF, 12'h123, 12'hABC, 12'h0F0, 12'h00F, 12'hF00};
      test_reset();
      test_priority();
      test_active_sync();
      test_flash();
      test_fade();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
